// File: rtl/avr_dmem_pkg.sv
// rtl/avr_dmem_pkg.sv - shared constants and types for the AVR data-memory responder
package avr_dmem_pkg;

  localparam int ADDR_W    = 16;
  localparam int DATA_W    = 8;
  localparam int MMIO_REGS = 5;

  localparam logic [2:0] TCNT_OFS = 3'd0;
  localparam logic [2:0] TCCR_OFS = 3'd1;
  localparam logic [2:0] TIFR_OFS = 3'd2;
  localparam logic [2:0] PORT_OFS = 3'd3;
  localparam logic [2:0] PIN_OFS  = 3'd4;

  typedef enum logic [2:0] {
    CS_STOP   = 3'd0,
    CS_DIV1   = 3'd1,
    CS_DIV8   = 3'd2,
    CS_DIV64  = 3'd3,
    CS_DIV256 = 3'd4
  } clk_sel_e;

  // Which source drives d_rdata in the cycle after the access.
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_SRAM = 2'd1,
    SRC_MMIO = 2'd2
  } rd_src_e;

endpackage

// File: rtl/avr_timer8.sv
// rtl/avr_timer8.sv - 8-bit timer/counter with prescaler, overflow flag and interrupt
module avr_timer8
  import avr_dmem_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              wr_en,
  input  logic [2:0]        wr_sel,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] tcnt,
  output logic [DATA_W-1:0] tccr,
  output logic [DATA_W-1:0] tifr,
  output logic              irq
);

  logic [7:0] prescaler, prescaler_d;
  logic [7:0] tcnt_q, tcnt_d;
  logic [2:0] clk_sel, clk_sel_d;
  logic       irq_en, irq_en_d;
  logic       ovf, ovf_d;
  logic       running, tick;
  logic       wr_tcnt, wr_tccr, wr_tifr;

  always_comb begin
    running = 1'b1;
    tick    = 1'b0;
    case (clk_sel)
      CS_DIV1:   tick = 1'b1;
      CS_DIV8:   tick = &prescaler[2:0];
      CS_DIV64:  tick = &prescaler[5:0];
      CS_DIV256: tick = &prescaler;
      default:   running = 1'b0;
    endcase
  end

  always_comb begin
    wr_tcnt = wr_en && (wr_sel == TCNT_OFS);
    wr_tccr = wr_en && (wr_sel == TCCR_OFS);
    wr_tifr = wr_en && (wr_sel == TIFR_OFS);

    prescaler_d = prescaler;
    if (wr_tccr)      prescaler_d = 8'h00;
    else if (running) prescaler_d = prescaler + 8'h01;

    clk_sel_d = clk_sel;
    irq_en_d  = irq_en;
    if (wr_tccr) begin
      clk_sel_d = wr_data[2:0];
      irq_en_d  = wr_data[7];
    end

    // A CPU write to TCNT swallows a coincident tick, including its overflow.
    tcnt_d = tcnt_q;
    ovf_d  = ovf;
    if (wr_tifr && wr_data[0]) ovf_d = 1'b0;
    if (wr_tcnt) begin
      tcnt_d = wr_data;
    end else if (tick) begin
      tcnt_d = tcnt_q + 8'h01;
      if (tcnt_q == 8'hFF) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      prescaler <= 8'h00;
      tcnt_q    <= 8'h00;
      clk_sel   <= 3'd0;
      irq_en    <= 1'b0;
      ovf       <= 1'b0;
      irq       <= 1'b0;
    end else begin
      prescaler <= prescaler_d;
      tcnt_q    <= tcnt_d;
      clk_sel   <= clk_sel_d;
      irq_en    <= irq_en_d;
      ovf       <= ovf_d;
      irq       <= ovf & irq_en;
    end
  end

  assign tcnt = tcnt_q;
  assign tccr = {irq_en, 4'b0000, clk_sel};
  assign tifr = {7'b0000000, ovf};

endmodule

// File: rtl/avr_dmem_responder.sv
// rtl/avr_dmem_responder.sv - data-memory responder: SRAM, timer and GPIO behind the core's d_addr port
module avr_dmem_responder
  import avr_dmem_pkg::*;
#(
  parameter logic [15:0] SRAM_BASE  = 16'h0060,
  parameter int          SRAM_DEPTH = 1024,
  parameter logic [15:0] MMIO_BASE  = 16'h0040
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic              d_we,
  output logic [DATA_W-1:0] d_rdata,
  input  logic [DATA_W-1:0] gpio_in,
  output logic [DATA_W-1:0] gpio_out,
  output logic              timer_irq
);

  localparam int IDX_W = $clog2(SRAM_DEPTH);

  logic [DATA_W-1:0] mem [SRAM_DEPTH];
  logic [ADDR_W-1:0] sram_ofs, mmio_ofs;
  logic [IDX_W-1:0]  sram_idx;
  logic              sram_hit, mmio_hit, mem_we, mmio_we;
  logic [DATA_W-1:0] sram_q, mmio_q, mmio_rd;
  logic [DATA_W-1:0] tcnt, tccr, tifr;
  logic [DATA_W-1:0] pin_s1, pin_q;
  rd_src_e           rd_src_q;

  // Offsets are taken at full width, so addresses below a base never alias into it.
  always_comb begin
    sram_ofs = d_addr - SRAM_BASE;
    mmio_ofs = d_addr - MMIO_BASE;
    sram_idx = sram_ofs[IDX_W-1:0];
    sram_hit = (d_addr >= SRAM_BASE) && (sram_ofs[ADDR_W-1:IDX_W] == '0);
    mmio_hit = (d_addr >= MMIO_BASE) && (mmio_ofs < 16'(MMIO_REGS));
    mem_we   = d_we && sram_hit && !RST;
    mmio_we  = d_we && mmio_hit && !RST;
  end

  avr_timer8 u_timer (
    .CLK     (CLK),
    .RST     (RST),
    .wr_en   (mmio_we),
    .wr_sel  (mmio_ofs[2:0]),
    .wr_data (d_wdata),
    .tcnt    (tcnt),
    .tccr    (tccr),
    .tifr    (tifr),
    .irq     (timer_irq)
  );

  always_comb begin
    mmio_rd = 8'h00;
    case (mmio_ofs[2:0])
      TCNT_OFS: mmio_rd = tcnt;
      TCCR_OFS: mmio_rd = tccr;
      TIFR_OFS: mmio_rd = tifr;
      PORT_OFS: mmio_rd = gpio_out;
      PIN_OFS:  mmio_rd = pin_q;
      default:  mmio_rd = 8'h00;
    endcase
  end

  // Read-first single-port RAM: the read samples the array before this edge's write lands.
  always_ff @(posedge CLK) begin
    if (mem_we) mem[sram_idx] <= d_wdata;
    sram_q <= mem[sram_idx];
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_src_q <= SRC_NONE;
      mmio_q   <= 8'h00;
      gpio_out <= 8'h00;
      pin_s1   <= 8'h00;
      pin_q    <= 8'h00;
    end else begin
      rd_src_q <= sram_hit ? SRC_SRAM : (mmio_hit ? SRC_MMIO : SRC_NONE);
      mmio_q   <= mmio_rd;
      if (mmio_we && (mmio_ofs[2:0] == PORT_OFS)) gpio_out <= d_wdata;
      pin_s1   <= gpio_in;
      pin_q    <= pin_s1;
    end
  end

  always_comb begin
    d_rdata = 8'h00;
    case (rd_src_q)
      SRC_SRAM: d_rdata = sram_q;
      SRC_MMIO: d_rdata = mmio_q;
      default:  d_rdata = 8'h00;
    endcase
  end

endmodule
